// File: rtl/seq_arith_bcd_display_if.sv
// Operand/result bundle for the sequential arithmetic unit with BCD/7-seg readout.
interface seq_arith_bcd_display_if #(
  parameter int W  = 4,
  parameter int RW = 2*W,
  parameter int ND = 3
);
  logic              start;
  logic [1:0]        mode;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic              acc_clr;
  logic              busy;
  logic              done;
  logic [RW-1:0]     result;
  logic              neg;
  logic              sat;
  logic [4*ND-1:0]   bcd;
  logic [7*ND-1:0]   seg;

  modport master (output start, mode, a, b, acc_clr,
                  input  busy, done, result, neg, sat, bcd, seg);
  modport slave  (input  start, mode, a, b, acc_clr,
                  output busy, done, result, neg, sat, bcd, seg);
endinterface

// File: rtl/seq_arith_bcd_display.sv
// Sequential add/sub/mul/mac unit; result converted by double-dabble and shown
// on ND seven-segment digits. Status outputs trail the internal state by a cycle.
module seq_arith_bcd_display #(
  parameter int W   = 4,
  parameter int RW  = 2*W,
  parameter int ND  = 3,
  parameter int LZB = 1
) (
  input logic                clk,
  input logic                rst,
  seq_arith_bcd_display_if.slave io
);
  localparam int CW = $clog2(RW) + 1;

  typedef enum logic [1:0] {IDLE, EXEC, CONV, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      mode_q;
  logic [RW-1:0]   mcand_q, prod_q, acc_q, result_q, sh_q;
  logic [W-1:0]    mplier_q;
  logic            neg_q, sat_q, busy_q, done_q;
  logic [4*ND-1:0] dd_q, bcd_q;
  logic [7*ND-1:0] seg_q;

  logic [RW-1:0]   prod_d, exec_res, sh_d;
  logic [RW:0]     mac_sum;
  logic [W-1:0]    diff;
  logic            exec_neg, exec_sat, exec_last;
  logic [4*ND-1:0] dd_adj, dd_d;

  function automatic logic [7*ND-1:0] seg_enc(input logic [4*ND-1:0] v);
    logic       nz;
    logic [6:0] s;
    seg_enc = '0;
    nz      = 1'b0;
    for (int i = ND-1; i >= 0; i--) begin
      nz = nz | (v[4*i +: 4] != 4'd0);
      case (v[4*i +: 4])
        4'd0: s = 7'h3F;  4'd1: s = 7'h06;  4'd2: s = 7'h5B;
        4'd3: s = 7'h4F;  4'd4: s = 7'h66;  4'd5: s = 7'h6D;
        4'd6: s = 7'h7D;  4'd7: s = 7'h07;  4'd8: s = 7'h7F;
        4'd9: s = 7'h6F;
        default: s = 7'h00;
      endcase
      if (LZB != 0 && i > 0 && !nz) s = 7'h00;
      seg_enc[7*i +: 7] = s;
    end
  endfunction

  assign prod_d  = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mac_sum = {1'b0, acc_q} + {1'b0, prod_d};

  always_comb begin
    exec_res  = '0;
    exec_neg  = 1'b0;
    exec_sat  = 1'b0;
    exec_last = 1'b1;
    diff      = '0;
    case (mode_q)
      2'b00: exec_res = mcand_q + RW'(mplier_q);
      2'b01: begin
        exec_neg = mcand_q[W-1:0] < mplier_q;
        diff     = exec_neg ? (mplier_q - mcand_q[W-1:0]) : (mcand_q[W-1:0] - mplier_q);
        exec_res = RW'(diff);
      end
      2'b10: begin
        exec_last = (cnt_q == CW'(W-1));
        exec_res  = prod_d;
      end
      default: begin
        exec_last = (cnt_q == CW'(W-1));
        exec_sat  = mac_sum[RW];
        exec_res  = mac_sum[RW] ? '1 : mac_sum[RW-1:0];
      end
    endcase
  end

  // Double-dabble step: add 3 to any digit >= 5, then shift {digits, shadow} left.
  always_comb begin
    dd_adj = '0;
    for (int i = 0; i < ND; i++)
      dd_adj[4*i +: 4] = (dd_q[4*i +: 4] >= 4'd5) ? dd_q[4*i +: 4] + 4'd3 : dd_q[4*i +: 4];
  end
  assign {dd_d, sh_d} = {dd_adj[4*ND-2:0], sh_q, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;  cnt_q <= '0;  mode_q <= '0;
      mcand_q <= '0;  mplier_q <= '0;  prod_q <= '0;  acc_q <= '0;
      result_q <= '0;  sh_q <= '0;  dd_q <= '0;  bcd_q <= '0;
      neg_q <= 1'b0;  sat_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;
      seg_q <= seg_enc('0);
    end else begin
      busy_q <= (state_q == EXEC) || (state_q == CONV);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) begin
            bcd_q <= dd_q;
            seg_q <= seg_enc(dd_q);
          end
          if (io.acc_clr) acc_q <= '0;
          if (io.start) begin
            mode_q   <= io.mode;
            mcand_q  <= RW'(io.a);
            mplier_q <= io.b;
            prod_q   <= '0;
            cnt_q    <= '0;
            state_q  <= EXEC;
          end else begin
            state_q  <= IDLE;
          end
        end
        EXEC: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (exec_last) begin
            result_q <= exec_res;
            neg_q    <= exec_neg;
            sat_q    <= exec_sat;
            if (mode_q == 2'b11) acc_q <= exec_res;
            sh_q     <= exec_res;
            dd_q     <= '0;
            cnt_q    <= '0;
            state_q  <= CONV;
          end
        end
        CONV: begin
          sh_q  <= sh_d;
          dd_q  <= dd_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(RW-1)) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.busy   = busy_q;
  assign io.done   = done_q;
  assign io.result = result_q;
  assign io.neg    = neg_q;
  assign io.sat    = sat_q;
  assign io.bcd    = bcd_q;
  assign io.seg    = seg_q;
endmodule

// File: tb/tb_seq_arith_bcd_display.sv
// Scoreboard bench: expected results queued at start, checked when done pulses.
module tb_seq_arith_bcd_display;
  localparam int W = 4, RW = 8, ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_arith_bcd_display_if #(.W(W), .RW(RW), .ND(ND)) io();
  seq_arith_bcd_display #(.W(W), .RW(RW), .ND(ND), .LZB(1)) dut (
    .clk(clk), .rst(rst), .io(io.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0]   res;
    logic            neg;
    logic            sat;
    logic [4*ND-1:0] bcd;
    logic [7*ND-1:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   model_acc = 0;

  function automatic logic [7*ND-1:0] ref_seg(input logic [4*ND-1:0] v);
    logic [6:0] s;
    logic       lead;
    ref_seg = '0;
    lead = 1'b1;
    for (int i = ND-1; i >= 0; i--) begin
      case (int'(v[4*i +: 4]))
        0: s = 7'h3F;  1: s = 7'h06;  2: s = 7'h5B;  3: s = 7'h4F;
        4: s = 7'h66;  5: s = 7'h6D;  6: s = 7'h7D;  7: s = 7'h07;
        8: s = 7'h7F;  9: s = 7'h6F;  default: s = 7'h00;
      endcase
      if (v[4*i +: 4] != 0) lead = 1'b0;
      if (lead && i > 0) s = 7'h00;
      ref_seg[7*i +: 7] = s;
    end
  endfunction

  task automatic issue(input logic [1:0] m, input int x, input int y, input bit clr);
    exp_t e;
    int   r;
    e = '0;
    if (clr) model_acc = 0;
    case (m)
      2'd0: r = x + y;
      2'd1: begin r = (x >= y) ? x - y : y - x; e.neg = (x < y); end
      2'd2: r = x * y;
      default: begin
        model_acc = model_acc + x * y;
        if (model_acc > 255) begin model_acc = 255; e.sat = 1'b1; end
        r = model_acc;
      end
    endcase
    e.res = RW'(r);
    e.bcd = {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
    e.seg = ref_seg(e.bcd);
    @(negedge clk);
    io.start = 1'b1; io.mode = m; io.a = W'(x); io.b = W'(y); io.acc_clr = clr;
    exp_q.push_back(e);
    @(negedge clk);
    io.start = 1'b0; io.acc_clr = 1'b0;
    io.a = W'($urandom); io.b = W'($urandom); io.mode = 2'($urandom);
  endtask

  // n = clock edges since accept when done is seen; bc = cycles busy was high.
  task automatic wait_done(input bit pulse, output int n, output int bc, output bit got);
    n = 0; bc = 0; got = 1'b0;
    while (!got && n < 60) begin
      if (io.done) got = 1'b1;
      else begin
        if (io.busy) bc++;
        io.start = pulse && (n >= 2) && (n <= 8);
        if (io.start) begin io.a = W'($urandom); io.b = W'($urandom); end
        @(negedge clk);
        n++;
      end
    end
    io.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({io.busy, io.done, io.result, io.neg, io.sat, io.bcd} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b res=%0d neg=%b sat=%b bcd=%h, want all 0",
               io.busy, io.done, io.result, io.neg, io.sat, io.bcd);
    end
    n_chk++;
    if (io.seg !== {7'h00, 7'h00, 7'h3F}) begin
      n_fail++; $display("FAIL reset_seg: got %h want %h", io.seg, {7'h00, 7'h00, 7'h3F});
    end
  endtask

  task automatic test_mul;
    int n, bc; bit got; exp_t e, o;
    issue(2'd2, 13, 11, 1'b0);
    wait_done(1'b0, n, bc, got);
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL mul_timeout: no done within %0d cycles", n); end
    e = exp_q.pop_front();
    o = {io.result, io.neg, io.sat, io.bcd, io.seg};
    n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL mul_result: got %h want %h", o, e); end
    n_chk++;
    if (n !== 13 || bc !== 12) begin
      n_fail++; $display("FAIL mul_latency: got done@%0d busy=%0d want done@13 busy=12", n, bc);
    end
    n_chk++;
    if (io.bcd !== 12'h143 || io.seg !== {7'h06, 7'h66, 7'h4F}) begin
      n_fail++; $display("FAIL mul_display: got bcd=%h seg=%h want 143 / %h", io.bcd, io.seg, {7'h06, 7'h66, 7'h4F});
    end
    @(negedge clk);
    n_chk++;
    if (io.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: done=%b want 0", io.done); end
  endtask

  task automatic test_add;
    int n, bc; bit got; exp_t e, o;
    issue(2'd0, 15, 15, 1'b0);
    wait_done(1'b0, n, bc, got);
    e = exp_q.pop_front();
    o = {io.result, io.neg, io.sat, io.bcd, io.seg};
    n_chk++;
    if (!got || o !== e) begin n_fail++; $display("FAIL add_result: got %h want %h (done=%b)", o, e, got); end
    n_chk++;
    if (n !== 10) begin n_fail++; $display("FAIL add_latency: got %0d want 10", n); end
    n_chk++;
    if (io.bcd !== 12'h030 || io.seg !== {7'h00, 7'h4F, 7'h3F}) begin
      n_fail++; $display("FAIL add_display: got bcd=%h seg=%h want 030 / %h", io.bcd, io.seg, {7'h00, 7'h4F, 7'h3F});
    end
  endtask

  task automatic test_sub;
    int n, bc; bit got; exp_t e, o;
    int xs[2] = '{3, 9};
    int ys[2] = '{9, 3};
    for (int i = 0; i < 2; i++) begin
      issue(2'd1, xs[i], ys[i], 1'b0);
      wait_done(1'b0, n, bc, got);
      e = exp_q.pop_front();
      o = {io.result, io.neg, io.sat, io.bcd, io.seg};
      n_chk++;
      if (!got || o !== e) begin n_fail++; $display("FAIL sub_%0d: got %h want %h (done=%b)", i, o, e, got); end
      n_chk++;
      if (io.neg !== (i == 0) || io.result !== 8'd6) begin
        n_fail++; $display("FAIL sub_neg_%0d: got res=%0d neg=%b want 6 / %b", i, io.result, io.neg, i == 0);
      end
    end
  endtask

  task automatic test_mac_sat;
    int n, bc; bit got; exp_t e, o;
    int xs[4] = '{10, 10, 15, 2};
    int ys[4] = '{10, 10, 15, 3};
    int rs[4] = '{100, 200, 255, 6};
    @(negedge clk); io.acc_clr = 1'b1; model_acc = 0;
    @(negedge clk); io.acc_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(2'd3, xs[i], ys[i], i == 3);
      wait_done(1'b0, n, bc, got);
      e = exp_q.pop_front();
      o = {io.result, io.neg, io.sat, io.bcd, io.seg};
      n_chk++;
      if (!got || o !== e || n !== 13) begin
        n_fail++; $display("FAIL mac_%0d: got %h @%0d want %h @13", i, o, n, e);
      end
      n_chk++;
      if (io.result !== 8'(rs[i]) || io.sat !== (i == 2)) begin
        n_fail++; $display("FAIL mac_sat_%0d: got res=%0d sat=%b want %0d / %b", i, io.result, io.sat, rs[i], i == 2);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n, bc, extra; bit got; exp_t e, o;
    issue(2'd2, 13, 11, 1'b0);
    wait_done(1'b1, n, bc, got);
    e = exp_q.pop_front();
    o = {io.result, io.neg, io.sat, io.bcd, io.seg};
    n_chk++;
    if (!got || o !== e || n !== 13) begin
      n_fail++; $display("FAIL ignore_start: got %h @%0d want %h @13", o, n, e);
    end
    extra = 0;
    repeat (25) begin @(negedge clk); if (io.done) extra++; end
    n_chk++;
    if (extra !== 0 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL ignore_extra_done: got %0d extra done pulses want 0", extra);
    end
  endtask

  task automatic test_rst_mid;
    int n, bc, dn; bit got; exp_t e, o;
    issue(2'd2, 13, 11, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_acc = 0;
    n_chk++;
    if (io.busy !== 1'b0 || io.done !== 1'b0 || io.result !== '0 || io.bcd !== '0 ||
        io.seg !== {7'h00, 7'h00, 7'h3F}) begin
      n_fail++; $display("FAIL rst_mid: got busy=%b done=%b res=%0d bcd=%h seg=%h want 0/0/0/0/%h",
                         io.busy, io.done, io.result, io.bcd, io.seg, {7'h00, 7'h00, 7'h3F});
    end
    dn = 0;
    repeat (20) begin @(negedge clk); if (io.done) dn++; end
    n_chk++;
    if (dn !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d done pulses want 0", dn); end
    issue(2'd0, 7, 8, 1'b0);
    wait_done(1'b0, n, bc, got);
    e = exp_q.pop_front();
    o = {io.result, io.neg, io.sat, io.bcd, io.seg};
    n_chk++;
    if (!got || o !== e || n !== 10) begin
      n_fail++; $display("FAIL rst_recover: got %h @%0d want %h @10", o, n, e);
    end
  endtask

  initial begin
    io.start = 1'b0; io.mode = '0; io.a = '0; io.b = '0; io.acc_clr = 1'b0;
    test_reset();
    test_mul();
    test_add();
    test_sub();
    test_mac_sat();
    test_back_to_back();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
